msf_slot_decoder: RTL and testbench



---
 rtl/msf_decoder_pkg.sv | 14 +
 rtl/msf_slot_voter.sv | 57 +++++
 rtl/msf_slot_decoder.sv | 159 +++++++++++++++
 tb/tb_msf_slot_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/msf_decoder_pkg.sv
// rtl/msf_decoder_pkg.sv - shared types and constants for the MSF slot decoder
package msf_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    TAIL
  } dec_state_e;

  localparam int SLOTS_PER_SECOND = 10;
  localparam int DECODE_SLOT      = 4;
  localparam logic [1:0] MARKER_DATA = 2'b11;

endpackage

// File: rtl/msf_slot_voter.sv
// rtl/msf_slot_voter.sv - per-slot sample counter and carrier-off majority vote
module msf_slot_voter
  import msf_decoder_pkg::*;
#(
  parameter int SAMPLES_PER_SLOT = 10,
  parameter int VOTE_THRESH      = 6,
  parameter int DEBOUNCE         = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_valid_i,
  input  logic sample_data_i,
  input  logic realign_i,
  output logic slot_done_o,
  output logic slot_vote_o
);

  localparam int CW = $clog2(SAMPLES_PER_SLOT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] off_q, off_d;
  logic [CW-1:0] off_inc;

  // Realign wins over a slot close: the debounce samples already belong to slot 0.
  always_comb begin
    off_inc     = off_q + CW'(sample_data_i);
    cnt_d       = cnt_q;
    off_d       = off_q;
    slot_done_o = 1'b0;
    slot_vote_o = 1'b0;
    if (sample_valid_i) begin
      if (realign_i) begin
        cnt_d = CW'(DEBOUNCE);
        off_d = CW'(DEBOUNCE);
      end else if (cnt_q == CW'(SAMPLES_PER_SLOT - 1)) begin
        slot_done_o = 1'b1;
        slot_vote_o = (off_inc >= CW'(VOTE_THRESH));
        cnt_d       = '0;
        off_d       = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        off_d = off_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      off_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/msf_slot_decoder.sv
// rtl/msf_slot_decoder.sv - MSF second tracker and {A,B}/minute-marker decoder
module msf_slot_decoder
  import msf_decoder_pkg::*;
#(
  parameter int SAMPLES_PER_SLOT = 10,
  parameter int VOTE_THRESH      = 6,
  parameter int DEBOUNCE         = 3,
  parameter int PERIOD_TOL       = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_valid_i,
  input  logic       sample_data_i,
  output logic       bits_valid_o,
  output logic       bits_is_second_00_o,
  output logic [1:0] bits_data_o,
  output logic       locked_o,
  output logic       error_o
);

  localparam int SEC_SAMPLES = SLOTS_PER_SECOND * SAMPLES_PER_SLOT;
  localparam int EL_MAX      = SEC_SAMPLES + PERIOD_TOL + 1;
  localparam int EW          = $clog2(EL_MAX + 1);
  localparam int RW          = $clog2(DEBOUNCE + 1);
  localparam int SW          = $clog2(SLOTS_PER_SECOND + 1);
  localparam logic [EW-1:0] WIN_LO = EW'(SEC_SAMPLES - PERIOD_TOL);
  localparam logic [EW-1:0] WIN_HI = EW'(SEC_SAMPLES + PERIOD_TOL);

  dec_state_e    state_q;
  logic          armed_q;
  logic [RW-1:0] run_q, run_d;
  logic [EW-1:0] elapsed_q, elapsed_d;
  logic [SW-1:0] slot_q;
  logic [2:0]    votes_q;
  logic          lock_ok_q;
  logic          bits_valid_q, s00_q, locked_q, error_q;
  logic [1:0]    data_q;

  logic       detect, realign, early, late;
  logic       slot_done, slot_vote;
  logic       fail, emit, emit_s00;
  logic [1:0] emit_data;

  msf_slot_voter #(
    .SAMPLES_PER_SLOT(SAMPLES_PER_SLOT),
    .VOTE_THRESH     (VOTE_THRESH),
    .DEBOUNCE        (DEBOUNCE)
  ) u_voter (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sample_valid_i(sample_valid_i),
    .sample_data_i (sample_data_i),
    .realign_i     (realign),
    .slot_done_o   (slot_done),
    .slot_vote_o   (slot_vote)
  );

  // Edges seen while collecting are B-bit or marker carrier-off runs, never a new second.
  always_comb begin
    detect    = sample_valid_i & sample_data_i & armed_q & (run_q == RW'(DEBOUNCE - 1));
    realign   = detect & (state_q != COLLECT);
    run_d     = (run_q == RW'(DEBOUNCE)) ? run_q : run_q + RW'(1);
    elapsed_d = (elapsed_q == EW'(EL_MAX)) ? elapsed_q : elapsed_q + EW'(1);
    early     = (elapsed_d < WIN_LO);
    late      = sample_valid_i & (elapsed_d > WIN_HI);
    fail      = 1'b0;
    emit      = 1'b0;
    emit_s00  = 1'b1;
    emit_data = MARKER_DATA;
    case (state_q)
      COLLECT: begin
        if (slot_done) begin
          if (slot_q == '0 && !slot_vote) begin
            fail = 1'b1;
          end else if (slot_q == SW'(DECODE_SLOT)) begin
            if (&{votes_q, slot_vote}) begin
              emit = 1'b1;
            end else if (!votes_q[0] && !slot_vote) begin
              emit      = 1'b1;
              emit_s00  = 1'b0;
              emit_data = votes_q[2:1];
            end else begin
              fail = 1'b1;
            end
          end
        end
      end
      TAIL: begin
        if (detect) begin
          fail = early | late;
        end else if (late) begin
          fail = 1'b1;
        end else if (slot_done && slot_vote && slot_q > SW'(DECODE_SLOT) &&
                     slot_q < SW'(SLOTS_PER_SECOND - 1)) begin
          fail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= HUNT;
      armed_q      <= 1'b0;
      run_q        <= '0;
      elapsed_q    <= '0;
      slot_q       <= '0;
      votes_q      <= '0;
      lock_ok_q    <= 1'b0;
      bits_valid_q <= 1'b0;
      s00_q        <= 1'b0;
      data_q       <= '0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      bits_valid_q <= 1'b0;
      error_q      <= 1'b0;
      if (sample_valid_i) begin
        if (!sample_data_i) begin
          armed_q <= 1'b1;
          run_q   <= '0;
        end else begin
          run_q <= run_d;
          if (detect) armed_q <= 1'b0;
        end
        elapsed_q <= realign ? EW'(DEBOUNCE) : elapsed_d;
        if (realign) slot_q <= '0;
        else if (slot_done && slot_q != SW'(SLOTS_PER_SECOND)) slot_q <= slot_q + SW'(1);
        if (state_q == COLLECT && slot_done) votes_q <= {votes_q[1:0], slot_vote};

        // A failing sample never leaves the detector armed, even if it was carrier-on.
        if (fail) begin
          error_q   <= 1'b1;
          locked_q  <= 1'b0;
          armed_q   <= 1'b0;
          lock_ok_q <= 1'b0;
          state_q   <= (realign && early) ? COLLECT : HUNT;
        end else if (emit) begin
          bits_valid_q <= 1'b1;
          data_q       <= emit_data;
          s00_q        <= emit_s00;
          if (lock_ok_q) locked_q <= 1'b1;
          state_q <= TAIL;
        end else if (realign) begin
          lock_ok_q <= 1'b1;
          state_q   <= COLLECT;
        end
      end
    end
  end

  assign bits_valid_o        = bits_valid_q;
  assign bits_is_second_00_o = s00_q;
  assign bits_data_o         = data_q;
  assign locked_o            = locked_q;
  assign error_o             = error_q;

endmodule

// File: tb/tb_msf_slot_decoder.sv
// tb/tb_msf_slot_decoder.sv - scoreboard bench for msf_slot_decoder at default parameters
module tb_msf_slot_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic       sample_data = 1'b0;
  logic       bits_valid;
  logic       bits_s00;
  logic [1:0] bits_data;
  logic       locked;
  logic       error;

  int total = 0;
  int bad   = 0;
  int n_drv = 0;
  int b;

  typedef struct {
    bit         err;
    logic [1:0] data;
    bit         s00;
    bit         lock;
    int         at;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  msf_slot_decoder dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .sample_valid_i     (sample_valid),
    .sample_data_i      (sample_data),
    .bits_valid_o       (bits_valid),
    .bits_is_second_00_o(bits_s00),
    .bits_data_o        (bits_data),
    .locked_o           (locked),
    .error_o            (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (sample %0d)", tag, got, exp, n_drv);
    end
  endtask

  task automatic drive(input bit d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    n_drv++;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic run(input bit d, input int n);
    repeat (n) drive(d);
  endtask

  // Two samples of each slot flipped: off count 8 or 2.
  task automatic noisy(input bit d);
    for (int i = 0; i < 10; i++) drive((i == 3 || i == 8) ? !d : d);
  endtask

  task automatic exp_bits(input int at, input logic [1:0] data, input bit s00, input bit lock);
    ev_t e;
    e.err = 1'b0; e.data = data; e.s00 = s00; e.lock = lock; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input int at);
    ev_t e;
    e.err = 1'b1; e.data = 2'b00; e.s00 = 1'b0; e.lock = 1'b0; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, bits_valid, 0);
    chk({tag, "_s00"}, bits_s00, 0);
    chk({tag, "_data"}, bits_data, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (bits_valid || error) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {bits_valid, error}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("kind", {bits_valid, error}, mon_e.err ? 2'b01 : 2'b10);
        chk("at_sample", n_drv, mon_e.at);
        chk("locked", locked, mon_e.lock);
        if (!mon_e.err) begin
          chk("data", bits_data, mon_e.data);
          chk("s00", bits_s00, mon_e.s00);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    run(0, 10);
    // data second A=1 B=0
    b = n_drv; exp_bits(b + 50, 2'b10, 0, 1);
    run(1, 20); run(0, 80);
    // minute marker, nominal period
    b = n_drv; exp_bits(b + 50, 2'b11, 1, 1);
    run(1, 50); run(0, 50);
    // noisy A=1 B=0, 92 samples so next detection lands at elapsed 95
    b = n_drv; exp_bits(b + 50, 2'b10, 0, 1);
    noisy(1); noisy(1); repeat (7) noisy(0); run(0, 2);
    // A=0 B=1 accepted at edge of window, 91 samples so next detection is at elapsed 94
    b = n_drv; exp_bits(b + 50, 2'b01, 0, 1);
    run(1, 10); run(0, 10); run(1, 10); run(0, 61);
    // early edge: error, realigned COLLECT decodes but stays unlocked
    b = n_drv; exp_err(b + 3); exp_bits(b + 50, 2'b00, 0, 0);
    run(1, 10); run(0, 90);
    // marker relocks, then carrier stays on until timeout
    b = n_drv; exp_bits(b + 50, 2'b11, 1, 1); exp_err(b + 106);
    run(1, 50); run(0, 60);
    // from HUNT again
    b = n_drv; exp_bits(b + 50, 2'b10, 0, 1);
    run(1, 20); run(0, 80);
    // reset mid-COLLECT together with a valid sample
    run(1, 20);
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b1; sample_data = 1'b1;
    @(posedge clk); #1;
    chk_idle("midrst");
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0;
    run(1, 30); run(0, 5);
    b = n_drv; exp_bits(b + 50, 2'b00, 0, 1);
    run(1, 10); run(0, 50);

    repeat (5) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
